// File: rtl/qr_combine_sequencer.sv
// -----------------------------------------------------------------------------
// qr_combine_sequencer
//
// Purpose:
//   Sequences one full QR capture as three downsampler passes. Each pass covers
//   one region of the code. The block stores each returned grid in its own slot.
//   It then builds the final grid from the three slots:
//     - top-left (x<10, y<10) comes from slot 0
//     - top-right (x>=10, y<10) comes from slot 1
//     - bottom (y>=10) comes from slot 2
//   The result goes out through a valid/ready handshake.
//   If a pass waits too long, the block drops the whole capture, pulses
//   timeout_out for one cycle and returns to idle.
//
// Ports:
//   clk_in        single clock, rising edge
//   rst_in        asynchronous active-high reset
//   start_in      request one capture (only honoured when idle)
//   ds_start_out  one-cycle start pulse to the downsampler
//   ds_pass_out   pass index 0/1/2 (region select), 0 when idle
//   ds_done_in    downsampler pass complete, ds_grid_in valid this cycle
//   ds_grid_in    downsampled grid of the current pass, bit x + y*CODE_SIZE
//   qr_code_out   combined QR grid, holds its value until the next combine
//   qr_valid_out  qr_code_out valid
//   qr_ready_in   consumer accepts qr_code_out
//   busy_out      high whenever the sequencer is not idle
//   timeout_out   one-cycle pulse when a pass times out
// -----------------------------------------------------------------------------
module qr_combine_sequencer #(
  parameter int unsigned CODE_SIZE      = 21,
  parameter int unsigned TIMEOUT_CYCLES = 1000000
) (
  input  logic                             clk_in,
  input  logic                             rst_in,
  input  logic                             start_in,
  output logic                             ds_start_out,
  output logic [1:0]                       ds_pass_out,
  input  logic                             ds_done_in,
  input  logic [CODE_SIZE*CODE_SIZE-1:0]   ds_grid_in,
  output logic [CODE_SIZE*CODE_SIZE-1:0]   qr_code_out,
  output logic                             qr_valid_out,
  input  logic                             qr_ready_in,
  output logic                             busy_out,
  output logic                             timeout_out
);

  localparam int unsigned GridBits = CODE_SIZE * CODE_SIZE;
  // Region boundary (in modules) between the three downsampler passes.
  localparam int          Split    = 10;
  localparam int unsigned CntW     = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [CntW-1:0] CntLast = CntW'(TIMEOUT_CYCLES - 1);

  typedef enum logic [2:0] {
    StIdle,
    StIssue,
    StWait,
    StCombine,
    StOutput
  } state_e;

  state_e              r_state;
  logic [1:0]          r_pass;
  logic [CntW-1:0]     r_cnt;
  logic [GridBits-1:0] r_slot0;
  logic [GridBits-1:0] r_slot1;
  logic [GridBits-1:0] r_slot2;
  logic [GridBits-1:0] r_qr_code;
  logic                r_qr_valid;
  logic                r_ds_start;
  logic                r_busy;
  logic                r_timeout;

  logic [GridBits-1:0] w_combined;

  // Static region map: every output bit is wired to exactly one slot bit.
  for (genvar gy = 0; gy < CODE_SIZE; gy++) begin : g_row
    for (genvar gx = 0; gx < CODE_SIZE; gx++) begin : g_col
      if (gy >= Split) begin : g_bottom
        assign w_combined[gx + gy*CODE_SIZE] = r_slot2[gx + gy*CODE_SIZE];
      end else if (gx < Split) begin : g_top_left
        assign w_combined[gx + gy*CODE_SIZE] = r_slot0[gx + gy*CODE_SIZE];
      end else begin : g_top_right
        assign w_combined[gx + gy*CODE_SIZE] = r_slot1[gx + gy*CODE_SIZE];
      end
    end
  end

  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      r_state    <= StIdle;
      r_pass     <= 2'd0;
      r_cnt      <= '0;
      r_slot0    <= '0;
      r_slot1    <= '0;
      r_slot2    <= '0;
      r_qr_code  <= '0;
      r_qr_valid <= 1'b0;
      r_ds_start <= 1'b0;
      r_busy     <= 1'b0;
      r_timeout  <= 1'b0;
    end else begin
      // Pulse outputs default low; they are raised only on the transition
      // that needs them.
      r_ds_start <= 1'b0;
      r_timeout  <= 1'b0;

      case (r_state)
        StIdle: begin
          if (start_in) begin
            r_state    <= StIssue;
            r_pass     <= 2'd0;
            r_cnt      <= '0;
            r_ds_start <= 1'b1;
            r_busy     <= 1'b1;
          end
        end

        StIssue: begin
          r_state <= StWait;
        end

        StWait: begin
          // done wins over timeout when both land in the same cycle
          if (ds_done_in) begin
            if (r_pass == 2'd0) begin
              r_slot0 <= ds_grid_in;
            end else if (r_pass == 2'd1) begin
              r_slot1 <= ds_grid_in;
            end else begin
              r_slot2 <= ds_grid_in;
            end

            if (r_pass == 2'd2) begin
              r_state <= StCombine;
            end else begin
              r_state    <= StIssue;
              r_pass     <= r_pass + 2'd1;
              r_cnt      <= '0;
              r_ds_start <= 1'b1;
            end
          end else if (r_cnt == CntLast) begin
            r_state   <= StIdle;
            r_pass    <= 2'd0;
            r_cnt     <= '0;
            r_timeout <= 1'b1;
            r_busy    <= 1'b0;
          end else begin
            r_cnt <= r_cnt + CntW'(1);
          end
        end

        StCombine: begin
          r_qr_code  <= w_combined;
          r_qr_valid <= 1'b1;
          r_state    <= StOutput;
        end

        StOutput: begin
          // qr_code_out is deliberately left untouched after the handshake
          if (qr_ready_in) begin
            r_qr_valid <= 1'b0;
            r_state    <= StIdle;
            r_pass     <= 2'd0;
            r_busy     <= 1'b0;
          end
        end

        default: begin
          r_state    <= StIdle;
          r_pass     <= 2'd0;
          r_cnt      <= '0;
          r_qr_valid <= 1'b0;
          r_busy     <= 1'b0;
        end
      endcase
    end
  end

  assign ds_start_out = r_ds_start;
  assign ds_pass_out  = r_pass;
  assign qr_code_out  = r_qr_code;
  assign qr_valid_out = r_qr_valid;
  assign busy_out     = r_busy;
  assign timeout_out  = r_timeout;

endmodule
